barrett_seq_ctrl: RTL and testbench

- Sequencing controller for the Barrett_2_reg radix-2^m modular-multiplier datapath.
- Accepts one operand set (A, B, M, mu) over a valid/ready handshake.
- Clears the datapath, then streams B's digits MSB-first into it, followed by one zero flush digit.
- Captures the datapath result, shifts it right by m, applies the final conditional subtraction, and returns Z = A*B mod M over a valid/ready output handshake.

---
 rtl/barrett_seq_ctrl_if.sv | 43 ++++
 rtl/barrett_seq_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_barrett_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/barrett_seq_ctrl_if.sv
// Operand/result handshake and datapath drive bundle for barrett_seq_ctrl.
// The out_err line exists only when BARRETT_SEQ_ERR_EN is defined.
interface barrett_seq_ctrl_if #(
    parameter int n = 8,
    parameter int m = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [n-1:0]     in_a;
    logic [n-1:0]     in_b;
    logic [n-1:0]     in_mod;
    logic [m+6:0]     in_mu;
    logic             out_valid;
    logic             out_ready;
    logic [n-1:0]     out_z;
`ifdef BARRETT_SEQ_ERR_EN
    logic             out_err;
`endif
    logic             dp_rst_n;
    logic [n-1:0]     dp_x;
    logic [m-1:0]     dp_y;
    logic [n-1:0]     dp_m;
    logic [m+6:0]     dp_mu;
    logic [2*n-1:0]   dp_z;

    // Controller side.
    modport slave (
        input  in_valid, in_a, in_b, in_mod, in_mu, out_ready, dp_z,
        output in_ready, out_valid, out_z, dp_rst_n, dp_x, dp_y, dp_m, dp_mu
`ifdef BARRETT_SEQ_ERR_EN
        , output out_err
`endif
    );

    // Producer/consumer and datapath side.
    modport master (
        output in_valid, in_a, in_b, in_mod, in_mu, out_ready, dp_z,
        input  in_ready, out_valid, out_z, dp_rst_n, dp_x, dp_y, dp_m, dp_mu
`ifdef BARRETT_SEQ_ERR_EN
        , input out_err
`endif
    );
endinterface

// File: rtl/barrett_seq_ctrl.sv
// Sequencer for the Barrett_2_reg radix-2^m modular multiplier: clear, feed B MSB-first,
// flush, capture, one conditional subtract. Optional BARRETT_SEQ_ERR_EN adds out_err.
module barrett_seq_ctrl #(
    parameter int n = 8,
    parameter int m = 4
) (
    input  logic              CLK,
    input  logic              RST,
    barrett_seq_ctrl_if.slave bus
);
    localparam int ND = n / m;
    localparam int KW = (ND > 1) ? $clog2(ND) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_CAPT  = 3'd4;
    localparam logic [2:0] S_CORR  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]     state_reg, state_next;
    logic [KW-1:0]  k_reg, k_next;
    logic [KW-1:0]  k_dec;
    logic [n-1:0]   a_reg, a_next;
    logic [n-1:0]   b_reg, b_next;
    logic [n-1:0]   mod_reg, mod_next;
    logic [m+6:0]   mu_reg, mu_next;
    logic [2*n-1:0] zs_reg, zs_next;
    logic [n-1:0]   out_z_reg, out_z_next;
    logic           out_valid_reg, out_valid_next;
    logic           in_ready_reg, in_ready_next;
    logic           dp_rst_n_reg, dp_rst_n_next;
    logic [m-1:0]   dp_y_reg, dp_y_next;

    logic [m-1:0]   b_digit [ND];
    logic [2*n-1:0] mod_ext;
    logic           zs_ge_mod;
    logic [n-1:0]   res_lo;

`ifdef BARRETT_SEQ_ERR_EN
    logic           err_reg, err_next;
    logic [2*n-1:0] res_full;
    logic           res_ge_mod;
    logic           mod_low;
`endif

    // B split into m-bit digits; digit gi feeds the datapath when k == gi.
    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_digit
            assign b_digit[gi] = b_reg[gi*m +: m];
        end
    endgenerate

    assign k_dec     = k_reg - KW'(1);
    assign mod_ext   = {{n{1'b0}}, mod_reg};
    assign zs_ge_mod = (zs_reg >= mod_ext);
    assign res_lo    = zs_ge_mod ? (zs_reg[n-1:0] - mod_reg) : zs_reg[n-1:0];

`ifdef BARRETT_SEQ_ERR_EN
    // A second correction would still be needed if res is not below M.
    assign res_full   = zs_ge_mod ? (zs_reg - mod_ext) : zs_reg;
    assign res_ge_mod = (res_full >= mod_ext);
    assign mod_low    = ~mod_reg[n-1];
`endif

    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        mod_next       = mod_reg;
        mu_next        = mu_reg;
        zs_next        = zs_reg;
        out_z_next     = out_z_reg;
        out_valid_next = out_valid_reg;
        in_ready_next  = in_ready_reg;
        dp_rst_n_next  = dp_rst_n_reg;
        dp_y_next      = '0;
`ifdef BARRETT_SEQ_ERR_EN
        err_next       = err_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                in_ready_next = 1'b1;
                dp_rst_n_next = 1'b1;
                if (bus.in_valid && in_ready_reg) begin
                    a_next        = bus.in_a;
                    b_next        = bus.in_b;
                    mod_next      = bus.in_mod;
                    mu_next       = bus.in_mu;
                    in_ready_next = 1'b0;
`ifdef BARRETT_SEQ_ERR_EN
                    // M=0 has no meaningful product; report it straight away.
                    if (bus.in_mod == '0) begin
                        zs_next    = '0;
                        state_next = S_CORR;
                    end else begin
                        dp_rst_n_next = 1'b0;
                        state_next    = S_CLR;
                    end
`else
                    dp_rst_n_next = 1'b0;
                    state_next    = S_CLR;
`endif
                end
            end

            S_CLR: begin
                dp_rst_n_next = 1'b1;
                k_next        = KW'(ND - 1);
                dp_y_next     = b_digit[ND-1];
                state_next    = S_FEED;
            end

            S_FEED: begin
                if (k_reg == '0) begin
                    state_next = S_FLUSH;
                end else begin
                    k_next    = k_dec;
                    dp_y_next = b_digit[k_dec];
                end
            end

            S_FLUSH: begin
                state_next = S_CAPT;
            end

            S_CAPT: begin
                // The flush digit leaves the product scaled by 2^m.
                zs_next    = bus.dp_z >> m;
                state_next = S_CORR;
            end

            S_CORR: begin
`ifdef BARRETT_SEQ_ERR_EN
                if (mod_reg == '0) begin
                    out_z_next = '0;
                    err_next   = 1'b1;
                end else begin
                    out_z_next = res_lo;
                    err_next   = mod_low | res_ge_mod;
                end
`else
                out_z_next = res_lo;
`endif
                out_valid_next = 1'b1;
                state_next     = S_DONE;
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                    state_next     = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg     <= S_IDLE;
            k_reg         <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            mod_reg       <= '0;
            mu_reg        <= '0;
            zs_reg        <= '0;
            out_z_reg     <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
            dp_rst_n_reg  <= 1'b0;
            dp_y_reg      <= '0;
`ifdef BARRETT_SEQ_ERR_EN
            err_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            mod_reg       <= mod_next;
            mu_reg        <= mu_next;
            zs_reg        <= zs_next;
            out_z_reg     <= out_z_next;
            out_valid_reg <= out_valid_next;
            in_ready_reg  <= in_ready_next;
            dp_rst_n_reg  <= dp_rst_n_next;
            dp_y_reg      <= dp_y_next;
`ifdef BARRETT_SEQ_ERR_EN
            err_reg       <= err_next;
`endif
        end
    end

    // Operand copies drive the datapath directly, so they stay stable while busy.
    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_z     = out_z_reg;
    assign bus.dp_rst_n  = dp_rst_n_reg;
    assign bus.dp_x      = a_reg;
    assign bus.dp_y      = dp_y_reg;
    assign bus.dp_m      = mod_reg;
    assign bus.dp_mu     = mu_reg;
`ifdef BARRETT_SEQ_ERR_EN
    assign bus.out_err   = err_reg;
`endif
endmodule

// File: tb/tb_barrett_seq_ctrl.sv
// Bench for barrett_seq_ctrl: behavioural radix-2^m datapath stand-in plus
// an A*B mod M reference; directed cases followed by random operand sets.
module tb_barrett_seq_ctrl;
    localparam int N  = 8;
    localparam int MW = 4;
    localparam int ND = N / MW;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    barrett_seq_ctrl_if #(.n(N), .m(MW)) bus ();
    barrett_seq_ctrl #(.n(N), .m(MW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Datapath stand-in: s accumulates s*2^m + X*Y modulo M*2^m, so after the
    // digits and the zero flush it holds (A*B mod M)*2^m. A random extra M*2^m
    // per operation exercises both outcomes of the final correction.
    longint dp_s;
    bit     dp_extra;

    function automatic longint dp_step(longint s, longint x, longint y, longint mm);
        longint t;
        t = s * (longint'(1) << MW) + x * y;
        if (mm != 0) t = t % (mm * (longint'(1) << MW));
        return t;
    endfunction

    always @(posedge CLK) begin
        if (!bus.dp_rst_n) begin
            dp_s     <= 0;
            dp_extra <= 1'($urandom_range(0, 1));
        end else begin
            dp_s <= dp_step(dp_s, longint'(bus.dp_x), longint'(bus.dp_y), longint'(bus.dp_m));
        end
    end
    assign bus.dp_z = (2*N)'(dp_s + (dp_extra ? (longint'(bus.dp_m) << MW) : 0));

    // One full operation; returns the cycle stamp of its input handshake.
    task automatic run_op(input int a, input int b, input int mod, input int hold,
                          input bit chk_z, output int t_in);
        int          waitc, edges, idx, rstlow, rst_idx, bad_ready, bad_hold, exp_lat;
        logic [3:0]  ysq [16];
        logic [N-1:0] z0;
        bit          skip_dp;
        int          exp_z;
        t_in    = 0;
        exp_z   = (mod != 0) ? (a * b) % mod : 0;
        exp_lat = ND + 5;
        skip_dp = 1'b0;
`ifdef BARRETT_SEQ_ERR_EN
        if (mod == 0) begin
            exp_lat = 2;
            skip_dp = 1'b1;
        end
`endif
        bus.out_ready = (hold == 0);
        waitc = 0;
        while (!bus.in_ready && waitc < 50) begin
            @(negedge CLK);
            waitc++;
        end
        check("idle_ready", bus.in_ready, 1);
        if (!bus.in_ready) return;

        bus.in_valid = 1'b1;
        bus.in_a     = N'(a);
        bus.in_b     = N'(b);
        bus.in_mod   = N'(mod);
        bus.in_mu    = (mod != 0) ? (MW+7)'(32768 / mod) : '0;
        @(posedge CLK);
        @(negedge CLK);
        t_in = cyc;
        check("busy_ready", bus.in_ready, 0);
        // Junk operands with in_valid high while busy must be ignored.
        bus.in_a   = N'($urandom);
        bus.in_b   = N'($urandom);
        bus.in_mod = N'($urandom);
        bus.in_mu  = (MW+7)'($urandom);

        edges = 0; idx = 0; rstlow = 0; rst_idx = -1; bad_ready = 0;
        while (!bus.out_valid && edges < 40) begin
            if (!bus.dp_rst_n) begin
                rstlow++;
                rst_idx = idx;
            end
            if (idx < 16) ysq[idx] = bus.dp_y;
            if (bus.in_ready) bad_ready++;
            idx++;
            @(negedge CLK);
            edges++;
        end
        bus.in_valid = 1'b0;
        // Edge at which out_valid is first sampled high, counted from the handshake edge.
        check("latency", edges + 1, exp_lat);
        if (!skip_dp) begin
            check("clr_cycles", rstlow, 1);
            check("clr_pos", rst_idx, 0);
            for (int j = 0; j < ND; j++)
                check("digit", ysq[1+j], (b >> (MW * (ND - 1 - j))) & ((1 << MW) - 1));
            check("flush_digit", ysq[ND+1], 0);
        end
        check("ready_low", bad_ready, 0);
        if (chk_z) check("out_z", bus.out_z, exp_z);
`ifdef BARRETT_SEQ_ERR_EN
        check("out_err", bus.out_err, (mod < (1 << (N - 1))) ? 1 : 0);
`endif

        z0 = bus.out_z;
        bad_hold = 0;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            @(negedge CLK);
            if (bus.out_z !== z0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                bad_hold++;
        end
        if (hold > 0) check("hold_stable", bad_hold, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge CLK);
        check("valid_drop", bus.out_valid, 0);
        check("ready_back", bus.in_ready, 1);
    endtask

    initial begin
        int t1, t2, ta, tb, mod_r;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_mod    = '0;
        bus.in_mu     = '0;
        bus.out_ready = 1'b1;

        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_z", bus.out_z, 0);
        check("rst_dp_rst_n", bus.dp_rst_n, 0);
        check("rst_dp_x", bus.dp_x, 0);
        check("rst_dp_y", bus.dp_y, 0);
        check("rst_dp_m", bus.dp_m, 0);
        check("rst_dp_mu", bus.dp_mu, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("idle_after_rst", bus.in_ready, 1);

        run_op(200, 150, 251, 0, 1'b1, t1);
        $display("op A=200 B=150 M=251 -> out_z=%0d", bus.out_z);
        run_op(5, 7, 131, 0, 1'b1, t1);
        $display("op A=5 B=7 M=131 -> out_z=%0d", bus.out_z);
        run_op(255, 255, 255, 0, 1'b1, t2);
        $display("op A=255 B=255 M=255 -> out_z=%0d", bus.out_z);
        check("throughput", t2 - t1, ND + 6);

        run_op(200, 150, 251, 10, 1'b1, t1);
        $display("op A=200 B=150 M=251 backpressure 10 -> out_z=%0d", bus.out_z);

        // Abort during FEED.
        bus.in_valid = 1'b1;
        bus.in_a = 8'd200; bus.in_b = 8'd150; bus.in_mod = 8'd251; bus.in_mu = 11'd130;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_dp_rst_n", bus.dp_rst_n, 0);
        check("abort_dp_y", bus.dp_y, 0);
        check("abort_dp_x", bus.dp_x, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_idle", bus.in_ready, 1);
        $display("reset during FEED -> in_ready=%0d out_valid=%0d", bus.in_ready, bus.out_valid);
        run_op(5, 7, 131, 0, 1'b1, t1);
        $display("op A=5 B=7 M=131 after abort -> out_z=%0d", bus.out_z);

        for (int i = 0; i < 24; i++) begin
            ta    = int'($urandom_range(0, 255));
            tb    = int'($urandom_range(0, 255));
            mod_r = int'($urandom_range(128, 255));
            run_op(ta, tb, mod_r, int'($urandom_range(0, 3)), 1'b1, t1);
            $display("op A=%0d B=%0d M=%0d -> out_z=%0d", ta, tb, mod_r, bus.out_z);
        end

        run_op(77, 33, 0, 1, 1'b0, t1);
        $display("op A=77 B=33 M=0 -> out_z=%0d", bus.out_z);
        run_op(77, 33, 100, 0, 1'b0, t1);
        $display("op A=77 B=33 M=100 -> out_z=%0d", bus.out_z);
        run_op(200, 150, 251, 0, 1'b1, t1);
        $display("op A=200 B=150 M=251 -> out_z=%0d", bus.out_z);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
